// File: rtl/holy_core_pkg.sv
`default_nettype none
// =============================================================================
// Module      : holy_core_pkg
// Description : Shared types for the holy core: ALU alignment flags, LSU FSM
//               states, load/store funct3 encodings and access-size decode.
// Revision    : 1.0 - initial release
// =============================================================================
package holy_core_pkg;

    typedef struct packed {
        logic word_aligned;
        logic halfword_aligned;
    } aligned_addr_signal;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Reserved encodings fall through to a full-word access.
    function automatic lsu_size_t lsu_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            F3_W:        return SZ_WORD;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/holy_lsu_align.sv
`default_nettype none
// =============================================================================
// Module      : holy_lsu_align
// Description : Combinational lane steering: load lane select + extension,
//               store strobe generation + lane replication.
// Revision    : 1.0 - initial release
// =============================================================================
module holy_lsu_align
    import holy_core_pkg::*;
(
    input  logic [2:0]  f3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    logic [7:0]  w_sel_b;
    logic [15:0] w_sel_h;
    logic        w_signed;

    assign w_signed = ~f3_i[2];

    always_comb begin
        w_sel_b     = word_i[{offset_i, 3'b000} +: 8];
        w_sel_h     = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o = word_i;
        wstrb_o     = 4'b1111;
        wdata_o     = wdata_i;
        case (lsu_size(f3_i))
            SZ_BYTE: begin
                load_data_o = {{24{w_sel_b[7] & w_signed}}, w_sel_b};
                wstrb_o     = 4'b0001 << offset_i;
                wdata_o     = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                // Halfword lane is chosen by addr[1] only; addr[0] wraps in-lane.
                load_data_o = {{16{w_sel_h[15] & w_signed}}, w_sel_h};
                wstrb_o     = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o     = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/holy_lsu.sv
`default_nettype none
// =============================================================================
// Module      : holy_lsu
// Description : Sequential load/store unit, one bus transaction per request.
//               Optional misaligned-access trap: HOLY_LSU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module holy_lsu
    import holy_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_f3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  aligned_addr_signal      req_aligned,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    stall,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
    ,
    output logic                    misaligned
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;

    lsu_state_t              state_q;
    logic                    req_ready_q;
    logic                    mem_req_valid_q;
    logic                    done_q;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [1:0]              offset_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    w_in_idle;
    logic                    w_accept;
    logic                    w_trap;
    logic [2:0]              w_f3;
    logic [1:0]              w_offset;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [STRB_W-1:0]       w_wstrb;
    logic [DATA_WIDTH-1:0]   w_wdata;

    assign w_in_idle = (state_q == IDLE);
    assign w_accept  = req_valid & req_ready_q;

    // The aligner serves the incoming store while idle and the pending load otherwise.
    assign w_f3     = w_in_idle ? req_f3 : f3_q;
    assign w_offset = w_in_idle ? req_addr[1:0] : offset_q;

    holy_lsu_align u_align (
        .f3_i        (w_f3),
        .offset_i    (w_offset),
        .word_i      (mem_rdata),
        .wdata_i     (req_wdata),
        .load_data_o (w_load_data),
        .wstrb_o     (w_wstrb),
        .wdata_o     (w_wdata)
    );

`ifdef HOLY_LSU_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_comb begin
        w_trap = 1'b0;
        case (lsu_size(req_f3))
            SZ_HALF: w_trap = ~req_aligned.halfword_aligned;
            SZ_WORD: w_trap = ~req_aligned.word_aligned;
            default: w_trap = 1'b0;
        endcase
    end

    assign misaligned = misaligned_q;
`else
    logic w_unused_aligned;

    assign w_trap           = 1'b0;
    assign w_unused_aligned = ^req_aligned;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            done_q          <= 1'b0;
            we_q            <= 1'b0;
            f3_q            <= 3'b000;
            offset_q        <= 2'b00;
            addr_q          <= '0;
            wstrb_q         <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
            misaligned_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        we_q        <= req_we;
                        f3_q        <= req_f3;
                        offset_q    <= req_addr[1:0];
                        addr_q      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        wstrb_q     <= req_we ? w_wstrb : '0;
                        wdata_q     <= req_we ? w_wdata : '0;
                        req_ready_q <= 1'b0;
                        if (w_trap) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
                            misaligned_q <= 1'b1;
`endif
                        end else begin
                            state_q         <= REQ;
                            mem_req_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (we_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        rdata_q <= w_load_data;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign done          = done_q;
    assign rdata         = rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_we        = we_q & mem_req_valid_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;
    assign stall         = (state_q == REQ) | (state_q == WAIT_RSP) | w_accept;

endmodule
`default_nettype wire

// File: tb/tb_holy_lsu.sv
`default_nettype none
// =============================================================================
// Module      : tb_holy_lsu
// Description : Self-checking bench for holy_lsu with a transaction-level model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_holy_lsu;
    import holy_core_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid, req_ready, req_we;
    logic [2:0]         req_f3;
    logic [31:0]        req_addr, req_wdata;
    aligned_addr_signal req_aligned;
    logic               done, stall;
    logic [31:0]        rdata;
    logic               mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;
    logic [3:0]         mem_wstrb;
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
    logic               misaligned;
`endif

    holy_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_f3        (req_f3),
        .req_addr      (req_addr),
        .req_aligned   (req_aligned),
        .req_wdata     (req_wdata),
        .done          (done),
        .rdata         (rdata),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_valid = 0, m_busy = 0, m_sent = 0, m_done_due = 0, m_mis = 0, m_we = 0;
    int          m_sz = 4, m_lane = 0;
    bit          m_sgn = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_mask = 0, m_rdata = 0;
    logic [3:0]  m_strb = 0;

    function automatic logic [31:0] extend(input logic [31:0] w, input int sz, input int lane, input bit sgn);
        logic [63:0] v, msk;
        msk = (64'd1 << (8 * sz)) - 64'd1;
        v   = ({32'd0, w} >> (8 * lane)) & msk;
        if (sgn && sz < 4 && v[8 * sz - 1]) v = v | ~msk;
        return v[31:0];
    endfunction

    task automatic model_accept();
        m_sz   = (req_f3[1:0] == 2'd0) ? 1 : (req_f3[1:0] == 2'd1) ? 2 : 4;
        m_lane = (m_sz == 1) ? int'(req_addr[1:0]) : (m_sz == 2) ? int'(req_addr[1:0] & 2'b10) : 0;
        m_sgn  = !req_f3[2];
        m_we   = req_we;
        m_addr = req_addr & 32'hFFFF_FFFC;
        m_strb = 4'(((1 << m_sz) - 1) << m_lane);
        m_wdata = req_wdata << (8 * m_lane);
        for (int i = 0; i < 4; i++) m_mask[8*i +: 8] = m_strb[i] ? 8'hFF : 8'h00;
        m_busy = 1; m_sent = 0; m_done_due = 0; m_mis = 0;
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
        if ((m_sz == 2 && !req_aligned.halfword_aligned) || (m_sz == 4 && !req_aligned.word_aligned)) begin
            m_done_due = 1; m_mis = 1;
        end
`endif
    endtask

    always @(negedge clk) begin
        done_cnt += int'(done);
        if (m_valid) begin
            check("req_ready", req_ready, !m_busy);
            check("done", done, m_done_due);
            check("stall", stall, (m_busy && !m_done_due) || (req_valid && !m_busy));
            check("mem_req_valid", mem_req_valid, m_busy && !m_sent && !m_done_due);
            check("rdata", rdata, m_rdata);
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
            check("misaligned", misaligned, m_done_due && m_mis);
`endif
            if (m_busy && !m_sent && !m_done_due) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", mem_we, m_we);
                if (m_we) begin
                    check("mem_wstrb", mem_wstrb, m_strb);
                    check("mem_wdata", mem_wdata & m_mask, m_wdata & m_mask);
                end
            end
        end
        if (rst) begin
            m_valid = 1; m_busy = 0; m_sent = 0; m_done_due = 0; m_mis = 0; m_rdata = 0;
        end else if (m_valid) begin
            if (m_done_due) begin
                m_busy = 0; m_done_due = 0; m_mis = 0;
            end else if (!m_busy) begin
                if (req_valid) model_accept();
            end else if (!m_sent) begin
                if (mem_req_ready) begin
                    m_sent = 1;
                    if (m_we) m_done_due = 1;
                end
            end else if (mem_rsp_valid) begin
                m_rdata = extend(mem_rdata, m_sz, m_lane, m_sgn);
                m_done_due = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rsp,
                          input int rdly, input int sdly,
                          output int lat, output bit saw_req, output logic [31:0] maddr,
                          output logic [3:0] mstrb, output logic [31:0] mwdata);
        int n, acc, rcnt, wcnt;
        bit hs;
        n = 0;
        while (!req_ready && n < 20) begin
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rdata     = $urandom;
            step();
            n++;
        end
        if (!req_ready) check("idle_timeout", 0, 1);
        req_valid = 1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
        req_aligned.word_aligned     = (addr[1:0] == 2'b00);
        req_aligned.halfword_aligned = !addr[0];
        mem_rsp_valid = 0;
        acc = cyc;
        step();
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_f3 = 3'($urandom);
        saw_req = 0; maddr = 0; mstrb = 0; mwdata = 0;
        hs = 0; rcnt = 0; wcnt = 0; n = 0;
        while (!done && n < 40) begin
            mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = $urandom;
            if (mem_req_valid) begin
                saw_req = 1; maddr = mem_addr; mstrb = mem_wstrb; mwdata = mem_wdata;
                if (rcnt >= rdly) begin
                    mem_req_ready = 1; hs = 1;
                end else begin
                    mem_rsp_valid = 1'($urandom_range(0, 1));
                end
                rcnt++;
            end else if (hs && !we) begin
                wcnt++;
                if (wcnt >= sdly) begin
                    mem_rsp_valid = 1; mem_rdata = rsp;
                end
            end
            step();
            n++;
        end
        mem_req_ready = 0; mem_rsp_valid = 0;
        if (!done) check("done_timeout", 0, 1);
        lat = cyc - acc;
    endtask

    int          lat;
    bit          saw;
    logic [31:0] ma, mw, held;
    logic [3:0]  ms;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_f3 = 0; req_addr = 0; req_wdata = 0;
        req_aligned = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        repeat (3) step();
        rst = 0;
        check("rst_req_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);

        do_txn(0, F3_B, 32'h0000_1003, 0, 32'h80FF_1234, 0, 1, lat, saw, ma, ms, mw);
        check("lb_addr", ma, 32'h0000_1000);
        check("lb_latency", lat, 3);
        check("lb_rdata", rdata, 32'hFFFF_FF80);

        do_txn(0, F3_HU, 32'h0000_2002, 0, 32'hBEEF_0000, 0, 1, lat, saw, ma, ms, mw);
        check("lhu_rdata", rdata, 32'h0000_BEEF);
        do_txn(0, F3_H, 32'h0000_2002, 0, 32'hBEEF_0000, 0, 2, lat, saw, ma, ms, mw);
        check("lh_rdata", rdata, 32'hFFFF_BEEF);

        do_txn(1, F3_B, 32'h0000_3001, 32'h0000_00AB, 0, 0, 1, lat, saw, ma, ms, mw);
        check("sb_wstrb", ms, 4'b0010);
        check("sb_wdata_lane", mw[15:8], 8'hAB);
        check("sb_latency", lat, 2);
        check("sb_rdata_kept", rdata, 32'hFFFF_BEEF);

        do_txn(1, F3_W, 32'h0000_3100, 32'hCAFE_F00D, 0, 4, 1, lat, saw, ma, ms, mw);
        check("sw_stall_latency", lat, 6);
        check("sw_wdata", mw, 32'hCAFE_F00D);

        // reset while the load waits for its response
        while (!req_ready) step();
        req_valid = 1; req_we = 0; req_f3 = F3_W; req_addr = 32'h0000_5000; req_aligned = 2'b11;
        step();
        req_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0; rst = 1;
        step();
        rst = 0; done_cnt = 0; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
        step();
        mem_rsp_valid = 0;
        step();
        check("rstmid_no_done", done_cnt, 0);
        check("rstmid_rdata", rdata, 0);
        check("rstmid_req_ready", req_ready, 1);

        do_txn(0, F3_W, 32'h0000_4002, 0, 32'hA5A5_5A5A, 0, 1, lat, saw, ma, ms, mw);
`ifdef HOLY_LSU_MISALIGN_TRAP_EN
        check("mis_no_bus", saw, 0);
        check("mis_latency", lat, 1);
        check("mis_flag", misaligned, 1);
        check("mis_rdata_kept", rdata, 0);
`else
        check("lw_wrap_addr", ma, 32'h0000_4000);
        check("lw_wrap_rdata", rdata, 32'hA5A5_5A5A);
`endif

        for (int i = 0; i < 150; i++) begin
            held = $urandom;
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, held,
                   $urandom_range(0, 3), $urandom_range(1, 3), lat, saw, ma, ms, mw);
        end
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/holy_lsu.md
Name: holy_lsu

Overview:
- Sequential load/store unit. Consumes the effective address and alignment flags produced by the ALU, and issues one data-memory transaction per accepted request over a valid/ready bus.
- Returns byte/halfword/word load data, aligned and sign- or zero-extended, to writeback.
- Sits between the execute stage and the data memory/cache port.
- Holds the core in stall while a transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of the effective address and of mem_addr.
- DATA_WIDTH, 32, data bus width. Only 32 is supported; wstrb is DATA_WIDTH/8 bits.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_f3  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective address (ALU result)
- req_aligned  in  aligned_addr_signal  word_aligned / halfword_aligned flags from the ALU
- req_wdata  in  32  store data (rs2), LSB-justified
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid while done=1
- stall  out  1  transaction outstanding (accepted but not done)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  word address (low 2 bits forced 00)
- mem_we  out  1  write enable
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  32  read data word

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. req_ready=1, all other outputs 0, rdata=0.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register we, f3, addr[1:0], word address, wstrb and shifted wdata, then go to REQ.
- REQ:
  - mem_req_valid=1 with stable addr/we/wstrb/wdata until mem_req_ready=1.
  - On the handshake: store goes to DONE; load goes to WAIT_RSP.
- WAIT_RSP:
  - mem_req_valid=0.
  - On mem_rsp_valid, capture the selected lane, extend it into the rdata register, then go to DONE.
  - A response in the same cycle as the request handshake is not permitted. The bus guarantees at least 1 cycle between them.
- DONE: done=1 for exactly one cycle, then IDLE.
- stall=1 in REQ, WAIT_RSP and on the accept cycle. stall=0 in DONE.
- Minimum latency, from accept at cycle 0:
  - Store: done at cycle 2.
  - Load: done at cycle 3.
- Lane select uses offset = addr[1:0]:
  - B/BU: byte offset.
  - H/HU: halfword addr[1].
  - W: whole word.
  - B and H sign-extend; BU and HU zero-extend.
- Store strobes:
  - SB: 0001<<offset.
  - SH: 0011<<offset (offset 0 or 2).
  - SW: 1111.
  - wdata is replicated or shifted into the matching lane.
- Unsupported f3 (011, 110, 111): treated as W.
- mem_rsp_valid outside WAIT_RSP is ignored.
- rdata holds its value until the next load completes. Stores do not modify rdata.
- Reset mid-operation returns to IDLE next cycle and drops mem_req_valid. A late response is discarded.

Optional Feature:
- Macro: HOLY_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misaligned (1 bit, reset 0).
  - A request whose req_aligned flag is false for its size (H/HU/SH need halfword_aligned; W/SW need word_aligned) does not reach the bus.
  - Accept goes straight to DONE with done=1 and misaligned=1 for that one cycle. rdata is unchanged.
- Undefined: alignment flags are ignored. The access uses the word address and in-lane offset, so it silently wraps within the word.

Decomposition:
- holy_core_pkg gains:
  - lsu_state_t enum (IDLE, REQ, WAIT_RSP, DONE).
  - f3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- aligned_addr_signal is reused from the package.
- One sub-module: holy_lsu_align. It is purely combinational: f3, offset and word in → extended load data; f3, offset and wdata in → wstrb and shifted wdata.
- The FSM and handshake logic stay in holy_lsu.

Test Plan:
- LB at 0x1003, mem_rdata=0x80FF_1234, mem_req_ready=1 immediately, response 1 cycle later → mem_addr=0x1000, done at cycle 3, rdata=0xFFFF_FF80.
- LHU at 0x2002, mem_rdata=0xBEEF_0000 → rdata=0x0000_BEEF. With LH instead → rdata=0xFFFF_BEEF.
- SB at 0x3001, wdata=0x0000_00AB → mem_we=1, wstrb=0010, mem_wdata[15:8]=0xAB, done at cycle 2, rdata unchanged.
- SW with mem_req_ready held low 4 cycles → mem_req_valid and payload stable for all 4, stall=1 throughout, done 1 cycle after the handshake.
- Load, then rst asserted while in WAIT_RSP, then response arrives → state IDLE, done never pulses, rdata=0, req_ready=1.
- With HOLY_LSU_MISALIGN_TRAP_EN defined, LW at 0x4002 → no mem_req_valid, done=1 and misaligned=1 the cycle after accept. Without the macro → mem_addr=0x4000, wstrb irrelevant, rdata = full word.
